// File: rtl/tlc5957_rx_if.sv
// Bundle between a TLC5957 lane (SCLK/LAT/SIN) and its receive-side decoder
// results: grayscale words, function-control words and protocol errors.
interface tlc5957_rx_if #(
  parameter int WORD_BITS = 48
);
  logic                 sclk;
  logic                 lat;
  logic                 sin;
  logic [WORD_BITS-1:0] gs_word;
  logic [3:0]           gs_index;
  logic                 gs_valid;
  logic                 latgs;
  logic [WORD_BITS-1:0] conf_word;
  logic                 conf_valid;
  logic                 fc_enabled;
  logic                 linereset;
  logic                 cmd_err;
  logic [2:0]           err_code;

  modport master (
    output sclk, lat, sin,
    input  gs_word, gs_index, gs_valid, latgs, conf_word, conf_valid,
           fc_enabled, linereset, cmd_err, err_code
  );

  modport slave (
    input  sclk, lat, sin,
    output gs_word, gs_index, gs_valid, latgs, conf_word, conf_valid,
           fc_enabled, linereset, cmd_err, err_code
  );
endinterface

// File: rtl/tlc5957_rx_decoder.sv
// Rebuilds TLC5957 48-bit shift-register words from a sampled SIN lane and
// decodes the LAT-length commands on each LAT falling edge.
module tlc5957_rx_decoder #(
  parameter int WORD_BITS = 48,
  parameter int GS_WRITES = 9,
  parameter int LAT_CNT_W = 5
) (
  input  logic            clk,
  input  logic            nrst,
  tlc5957_rx_if.slave     bus
);
  localparam logic [5:0]           FULL_BITS = 6'(WORD_BITS);
  localparam logic [5:0]           BIT_MAX   = 6'd63;
  localparam logic [3:0]           LAST_IDX  = 4'(GS_WRITES - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_MAX   = {LAT_CNT_W{1'b1}};

  localparam logic [LAT_CNT_W-1:0] LEN_WRTGS     = LAT_CNT_W'(1);
  localparam logic [LAT_CNT_W-1:0] LEN_LATGS     = LAT_CNT_W'(3);
  localparam logic [LAT_CNT_W-1:0] LEN_WRTFC     = LAT_CNT_W'(5);
  localparam logic [LAT_CNT_W-1:0] LEN_LINERESET = LAT_CNT_W'(7);
  localparam logic [LAT_CNT_W-1:0] LEN_READFC    = LAT_CNT_W'(11);
  localparam logic [LAT_CNT_W-1:0] LEN_FCWRTEN   = LAT_CNT_W'(15);

  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_BITS = 3'd2;
  localparam logic [2:0] ERR_NOFC = 3'd3;
  localparam logic [2:0] ERR_SEQ  = 3'd4;

  logic [WORD_BITS-1:0] sr_r;
  logic [5:0]           bit_cnt_r;
  logic [LAT_CNT_W-1:0] lat_cnt_r;
  logic                 lat_q_r;
  logic [3:0]           idx_r;
  logic                 fall_s;
  logic                 bits_ok_s;

  assign fall_s    = lat_q_r & ~bus.lat;
  assign bits_ok_s = (bit_cnt_r == FULL_BITS);

  // Word assembly, LAT-length counting and command decode on LAT fall.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sr_r           <= '0;
      bit_cnt_r      <= 6'd0;
      lat_cnt_r      <= '0;
      lat_q_r        <= 1'b0;
      idx_r          <= 4'd0;
      bus.gs_word    <= '0;
      bus.gs_index   <= 4'd0;
      bus.gs_valid   <= 1'b0;
      bus.latgs      <= 1'b0;
      bus.conf_word  <= '0;
      bus.conf_valid <= 1'b0;
      bus.fc_enabled <= 1'b0;
      bus.linereset  <= 1'b0;
      bus.cmd_err    <= 1'b0;
      bus.err_code   <= 3'd0;
    end else begin
      lat_q_r        <= bus.lat;
      bus.gs_valid   <= 1'b0;
      bus.latgs      <= 1'b0;
      bus.conf_valid <= 1'b0;
      bus.linereset  <= 1'b0;
      bus.cmd_err    <= 1'b0;
      if (bus.sclk) begin
        sr_r <= {sr_r[WORD_BITS-2:0], bus.sin};
      end
      if (fall_s) begin
        // Decode sees the pre-edge sr/counters; a coincident sclk is bit 1.
        lat_cnt_r <= '0;
        bit_cnt_r <= bus.sclk ? 6'd1 : 6'd0;
        case (lat_cnt_r)
          LEN_WRTGS: begin
            bus.fc_enabled <= 1'b0;
            if (idx_r >= LAST_IDX) begin
              bus.cmd_err  <= 1'b1;
              bus.err_code <= ERR_SEQ;
              idx_r        <= 4'd0;
            end else if (!bits_ok_s) begin
              bus.cmd_err  <= 1'b1;
              bus.err_code <= ERR_BITS;
              idx_r        <= idx_r + 4'd1;
            end else begin
              bus.gs_valid <= 1'b1;
              bus.gs_word  <= sr_r;
              bus.gs_index <= idx_r;
              idx_r        <= idx_r + 4'd1;
            end
          end
          LEN_LATGS: begin
            bus.fc_enabled <= 1'b0;
            if (idx_r != LAST_IDX) begin
              bus.cmd_err  <= 1'b1;
              bus.err_code <= ERR_SEQ;
              idx_r        <= 4'd0;
            end else if (!bits_ok_s) begin
              bus.cmd_err  <= 1'b1;
              bus.err_code <= ERR_BITS;
            end else begin
              bus.gs_valid <= 1'b1;
              bus.latgs    <= 1'b1;
              bus.gs_word  <= sr_r;
              bus.gs_index <= idx_r;
              idx_r        <= 4'd0;
            end
          end
          LEN_WRTFC: begin
            if (!bus.fc_enabled) begin
              bus.cmd_err  <= 1'b1;
              bus.err_code <= ERR_NOFC;
            end else if (!bits_ok_s) begin
              bus.cmd_err  <= 1'b1;
              bus.err_code <= ERR_BITS;
            end else begin
              bus.conf_valid <= 1'b1;
              bus.conf_word  <= sr_r;
              bus.fc_enabled <= 1'b0;
            end
          end
          LEN_FCWRTEN: begin
            bus.fc_enabled <= 1'b1;
          end
          LEN_LINERESET: begin
            bus.linereset  <= 1'b1;
            bus.fc_enabled <= 1'b0;
            idx_r          <= 4'd0;
          end
          LEN_READFC: begin
            idx_r <= idx_r;
          end
          default: begin
            bus.cmd_err    <= 1'b1;
            bus.err_code   <= ERR_LEN;
            bus.fc_enabled <= 1'b0;
          end
        endcase
      end else if (bus.sclk) begin
        if (bit_cnt_r != BIT_MAX) begin
          bit_cnt_r <= bit_cnt_r + 6'd1;
        end
        if (bus.lat && (lat_cnt_r != LAT_MAX)) begin
          lat_cnt_r <= lat_cnt_r + LAT_CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_tlc5957_rx_decoder.sv
// Bench for tlc5957_rx_decoder: a behavioural protocol model pushes expected
// strobe events into a queue; the negedge monitor pops and compares them.
module tb_tlc5957_rx_decoder;
  logic clk = 1'b0;
  logic nrst;
  int   cyc = 0;

  tlc5957_rx_if bus ();

  tlc5957_rx_decoder dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected events can be pinned to a cycle.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [108:0] v;
  } ev_t;

  ev_t         q[$];
  int          checks = 0;
  int          errors = 0;
  logic [47:0] m_sr, m_gs_word, m_conf;
  int          m_bits, m_lat, m_idx;
  logic [3:0]  m_gs_index;
  logic [2:0]  m_err;
  logic        m_fc;

  function automatic logic [108:0] pack(logic gv, logic lg, logic [3:0] gi, logic [47:0] gw,
                                        logic cv, logic [47:0] cw, logic lr, logic ce,
                                        logic [2:0] ec, logic fe);
    return {gv, lg, gi, gw, cv, cw, lr, ce, ec, fe};
  endfunction

  function automatic logic [108:0] actual();
    return pack(bus.gs_valid, bus.latgs, bus.gs_index, bus.gs_word, bus.conf_valid,
                bus.conf_word, bus.linereset, bus.cmd_err, bus.err_code, bus.fc_enabled);
  endfunction

  task automatic m_reset();
    m_sr = 48'h0; m_gs_word = 48'h0; m_conf = 48'h0;
    m_bits = 0; m_lat = 0; m_idx = 0;
    m_gs_index = 4'd0; m_err = 3'd0; m_fc = 1'b0;
    q.delete();
  endtask

  task automatic m_shift(input logic b, input logic l);
    m_sr = {m_sr[46:0], b};
    if (m_bits < 63) m_bits++;
    if (l && m_lat < 31) m_lat++;
  endtask

  task automatic m_decode(input int at);
    logic gv = 1'b0, lg = 1'b0, cv = 1'b0, lr = 1'b0, ce = 1'b0;
    ev_t  e;
    case (m_lat)
      1: begin
        m_fc = 1'b0;
        if (m_idx == 8) begin ce = 1'b1; m_err = 3'd4; m_idx = 0; end
        else if (m_bits != 48) begin ce = 1'b1; m_err = 3'd2; m_idx++; end
        else begin gv = 1'b1; m_gs_word = m_sr; m_gs_index = 4'(m_idx); m_idx++; end
      end
      3: begin
        m_fc = 1'b0;
        if (m_idx != 8) begin ce = 1'b1; m_err = 3'd4; m_idx = 0; end
        else if (m_bits != 48) begin ce = 1'b1; m_err = 3'd2; end
        else begin gv = 1'b1; lg = 1'b1; m_gs_word = m_sr; m_gs_index = 4'd8; m_idx = 0; end
      end
      5: begin
        if (!m_fc) begin ce = 1'b1; m_err = 3'd3; end
        else if (m_bits != 48) begin ce = 1'b1; m_err = 3'd2; end
        else begin cv = 1'b1; m_conf = m_sr; m_fc = 1'b0; end
      end
      15: m_fc = 1'b1;
      7: begin lr = 1'b1; m_idx = 0; m_fc = 1'b0; end
      11: ;
      default: begin ce = 1'b1; m_err = 3'd1; m_fc = 1'b0; end
    endcase
    if (gv | cv | lr | ce) begin
      e.cyc = at;
      e.v   = pack(gv, lg, m_gs_index, m_gs_word, cv, m_conf, lr, ce, m_err, m_fc);
      q.push_back(e);
    end
    m_lat  = 0;
    m_bits = 0;
  endtask

  // Advance to the next falling edge and reconcile DUT strobes with the queue.
  task automatic tick();
    ev_t e;
    @(negedge clk);
    if (nrst) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_strobe cyc=%0d got=none want=%h", e.cyc, e.v);
      end
      if (bus.gs_valid | bus.latgs | bus.conf_valid | bus.linereset | bus.cmd_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got=%h want=none", cyc, actual());
        end else begin
          e = q.pop_front();
          if (e.cyc !== cyc || actual() !== e.v) begin
            errors++;
            $display("FAIL scoreboard cyc=%0d/%0d got=%h want=%h", cyc, e.cyc, actual(), e.v);
          end
        end
      end
    end
  endtask

  task automatic clk_bit(input logic b, input logic l);
    tick();
    bus.sclk = 1'b1; bus.sin = b; bus.lat = l;
    m_shift(b, l);
  endtask

  task automatic clk_fall(input logic s, input logic b);
    tick();
    bus.lat = 1'b0; bus.sclk = s; bus.sin = b;
    m_decode(cyc + 1);
    if (s) m_shift(b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin tick(); bus.sclk = 1'b0; end
  endtask

  task automatic send_word(input logic [47:0] w, input int nbits, input int latn);
    for (int i = 0; i < nbits; i++) clk_bit(w[nbits-1-i], (i >= nbits - latn));
  endtask

  task automatic test_reset();
    nrst = 1'b0; bus.sclk = 1'b0; bus.lat = 1'b0; bus.sin = 1'b0;
    m_reset();
    idle(3);
    checks++;
    if (actual() !== 109'h0) begin
      errors++; $display("FAIL reset_in got=%h want=0", actual());
    end
    nrst = 1'b1;
    idle(2);
    checks++;
    if (actual() !== 109'h0) begin
      errors++; $display("FAIL reset_out got=%h want=0", actual());
    end
  endtask

  task automatic test_fc_write();
    send_word(48'h0, 15, 15); clk_fall(1'b0, 1'b0); idle(2);
    checks++;
    if (bus.fc_enabled !== 1'b1) begin
      errors++; $display("FAIL fc_enable got=%b want=1", bus.fc_enabled);
    end
    send_word(48'h123456789ABC, 48, 5); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.conf_word !== 48'h123456789ABC || bus.fc_enabled !== 1'b0 || bus.conf_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrtfc got=%h/%b/%b want=123456789abc/0/1", bus.conf_word, bus.fc_enabled, bus.conf_valid);
    end
    idle(2);
  endtask

  task automatic test_wrtfc_no_enable();
    send_word(48'hFFFF0000FFFF, 48, 5); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.cmd_err !== 1'b1 || bus.err_code !== 3'd3 || bus.conf_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrtfc_noen got=%b/%0d/%b want=1/3/0", bus.cmd_err, bus.err_code, bus.conf_valid);
    end
    idle(2);
  endtask

  task automatic test_gs_frame();
    for (int k = 0; k < 9; k++) begin
      send_word(48'(k) * 48'h010101010101, 48, (k == 8) ? 3 : 1);
      clk_fall(1'b0, 1'b0); tick();
      checks++;
      if (bus.gs_valid !== 1'b1 || bus.gs_index !== 4'(k) || bus.latgs !== (k == 8)) begin
        errors++;
        $display("FAIL gs_frame k=%0d got=%b/%0d/%b want=1/%0d/%b", k, bus.gs_valid, bus.gs_index, bus.latgs, k, (k == 8));
      end
      idle(1);
    end
  endtask

  task automatic test_errors();
    send_word(48'hAA55AA55AA55, 40, 1); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.err_code !== 3'd2) begin
      errors++; $display("FAIL short_word got=%0d want=2", bus.err_code);
    end
    send_word(48'h111111111111, 48, 1); clk_fall(1'b0, 1'b0); idle(1);
    send_word(48'h222222222222, 48, 1); clk_fall(1'b0, 1'b0); idle(1);
    send_word(48'h333333333333, 48, 3); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.err_code !== 3'd4) begin
      errors++; $display("FAIL latgs_early got=%0d want=4", bus.err_code);
    end
    send_word(48'hC0FFEE123456, 48, 1); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.gs_index !== 4'd0 || bus.gs_word !== 48'hC0FFEE123456) begin
      errors++; $display("FAIL idx_restart got=%0d/%h want=0/c0ffee123456", bus.gs_index, bus.gs_word);
    end
    tick(); bus.lat = 1'b1; bus.sclk = 1'b0;
    idle(2); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.err_code !== 3'd1) begin
      errors++; $display("FAIL lat_no_sclk got=%0d want=1", bus.err_code);
    end
    send_word(48'h0, 7, 7); clk_fall(1'b0, 1'b0); idle(2);
    send_word(48'h0, 11, 11); clk_fall(1'b0, 1'b0); idle(2);
  endtask

  task automatic test_back_to_back();
    logic [47:0] wa, wb;
    wa = 48'h5A5A12345678;
    wb = 48'h87654321A5A5;
    send_word(wa, 48, 1);
    clk_fall(1'b1, wb[47]);
    for (int i = 1; i < 48; i++) begin
      clk_bit(wb[47-i], (i == 47));
      if (i == 1) begin
        checks++;
        if (bus.gs_word !== wa) begin
          errors++; $display("FAIL b2b_first got=%h want=%h", bus.gs_word, wa);
        end
      end
    end
    clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.gs_valid !== 1'b1 || bus.gs_word !== wb || bus.cmd_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second got=%b/%h want=1/%h", bus.gs_valid, bus.gs_word, wb);
    end
    idle(2);
  endtask

  task automatic test_reset_midword();
    send_word(48'hDEADBEEFCAFE, 20, 0);
    tick(); nrst = 1'b0; bus.sclk = 1'b0; bus.lat = 1'b0;
    m_reset();
    idle(2);
    checks++;
    if (actual() !== 109'h0) begin
      errors++; $display("FAIL reset_mid got=%h want=0", actual());
    end
    nrst = 1'b1;
    idle(1);
    send_word(48'h0F0E0D0C0B0A, 48, 1); clk_fall(1'b0, 1'b0); tick();
    checks++;
    if (bus.gs_index !== 4'd0 || bus.gs_word !== 48'h0F0E0D0C0B0A) begin
      errors++; $display("FAIL after_reset got=%0d/%h want=0/0f0e0d0c0b0a", bus.gs_index, bus.gs_word);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_fc_write();
    test_wrtfc_no_enable();
    test_gs_frame();
    test_errors();
    test_back_to_back();
    test_reset_midword();
    idle(4);
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
